// File: rtl/cell_operand_bank.sv
// ---------------------------------------------------------------------------
// cell_operand_bank
//
// Eight-entry operand register bank that feeds an external combinational ALU
// cell. The host fills registers through the load port; the instruction port
// latches the cell controls, lets the cell evaluate for one cycle, then writes
// the cell result back into a destination register and pulses done.
//
// Parameters
//   WIDTH         data word width (default 32)
//
// Ports
//   clk           single clock, all state changes on its rising edge
//   rst_n         synchronous active-low reset
//   load_valid    host write request
//   load_ready    bank can accept a host write (high in IDLE)
//   load_addr     host write register index
//   load_data     host write data
//   instr_valid   instruction request
//   instr_ready   bank can accept an instruction (IDLE with no load pending)
//   instr_sel0    operand 0 register select
//   instr_sel1    operand 1 register select
//   instr_dst     destination register index
//   instr_selop   ALU cell operation select
//   instr_bypass  ALU cell bypass control
//   reg0..reg7    register contents, wired to the cell operand inputs
//   cell_sel0     latched operand 0 select
//   cell_sel1     latched operand 1 select
//   cell_selop    latched operation select
//   cell_bypass   latched bypass control
//   cell_result   combinational result from the ALU cell
//   done          one-cycle strobe following each writeback
//   zero_flag     (only with CELL_BANK_ZERO_FLAG_EN) result of the last
//                 writeback was zero
//
// Optional feature macro: CELL_BANK_ZERO_FLAG_EN
// ---------------------------------------------------------------------------
module cell_operand_bank #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [2:0]       load_addr,
   input  logic [WIDTH-1:0] load_data,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [2:0]       instr_sel0,
   input  logic [2:0]       instr_sel1,
   input  logic [2:0]       instr_dst,
   input  logic [1:0]       instr_selop,
   input  logic             instr_bypass,
   output logic [WIDTH-1:0] reg0,
   output logic [WIDTH-1:0] reg1,
   output logic [WIDTH-1:0] reg2,
   output logic [WIDTH-1:0] reg3,
   output logic [WIDTH-1:0] reg4,
   output logic [WIDTH-1:0] reg5,
   output logic [WIDTH-1:0] reg6,
   output logic [WIDTH-1:0] reg7,
   output logic [2:0]       cell_sel0,
   output logic [2:0]       cell_sel1,
   output logic [1:0]       cell_selop,
   output logic             cell_bypass,
   input  logic [WIDTH-1:0] cell_result,
   output logic             done
`ifdef CELL_BANK_ZERO_FLAG_EN
   ,
   output logic             zero_flag
`endif
);

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] regs [8];
   logic [2:0]       dst_q;

   // The handshake ready signals come straight from the state register.
   // A pending load blocks the instruction port so the load always wins a
   // same-cycle contest and the instruction simply retries next cycle.
   assign load_ready  = (state == IDLE);
   assign instr_ready = (state == IDLE) && !load_valid;

   // Register file contents are exposed permanently to the ALU cell.
   assign reg0 = regs[0];
   assign reg1 = regs[1];
   assign reg2 = regs[2];
   assign reg3 = regs[3];
   assign reg4 = regs[4];
   assign reg5 = regs[5];
   assign reg6 = regs[6];
   assign reg7 = regs[7];

   // Main controller. In IDLE a load writes the register file directly, or
   // an instruction latches the cell controls and moves to ISSUE. During
   // ISSUE the cell sees stable selects and the current register values, so
   // a destination that matches a source still reads the old value; the
   // result is committed on the edge that leaves ISSUE. done defaults low
   // every cycle so it only survives the single cycle after a writeback.
   // Reset overrides everything, which also discards an instruction that
   // was in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         for (int i = 0; i < 8; i++) begin
            regs[i] <= '0;
         end
         cell_sel0   <= '0;
         cell_sel1   <= '0;
         cell_selop  <= '0;
         cell_bypass <= 1'b0;
         dst_q       <= '0;
         done        <= 1'b0;
`ifdef CELL_BANK_ZERO_FLAG_EN
         zero_flag   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (load_valid) begin
                  regs[load_addr] <= load_data;
               end else if (instr_valid) begin
                  cell_sel0   <= instr_sel0;
                  cell_sel1   <= instr_sel1;
                  cell_selop  <= instr_selop;
                  cell_bypass <= instr_bypass;
                  dst_q       <= instr_dst;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               regs[dst_q] <= cell_result;
               done        <= 1'b1;
`ifdef CELL_BANK_ZERO_FLAG_EN
               zero_flag   <= (cell_result == '0);
`endif
               state       <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/cell_operand_bank.md
CELL_OPERAND_BANK -- requirements
Module: cell_operand_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the data word width.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, reset that is synchronous and active-low.
REQ-004 SHALL have ports load_valid / load_ready (input / output, 1 bit each), load_addr (input, 3 bits), load_data (input, WIDTH bits), forming the host register-write port.
REQ-005 SHALL have ports instr_valid / instr_ready (input / output, 1 bit each), instr_sel0, instr_sel1, instr_dst (input, 3 bits each), instr_selop (input, 2 bits), instr_bypass (input, 1 bit), forming the instruction port.
REQ-006 SHALL have ports reg0..reg7 (output, WIDTH bits each), the register contents driving the ALU cell operand inputs 0..7.
REQ-007 SHALL have ports cell_sel0, cell_sel1 (output, 3 bits each), cell_selop (output, 2 bits), cell_bypass (output, 1 bit), the ALU cell controls.
REQ-008 SHALL have port cell_result (input, WIDTH bits), the combinational ALU cell result.
REQ-009 SHALL have port done (output, 1 bit), a one-cycle writeback strobe.

Function
REQ-010 SHALL hold eight WIDTH-bit registers R0..R7, driven continuously on reg0..reg7.
REQ-011 SHALL implement FSM states IDLE and ISSUE.
REQ-012 In IDLE: load_ready=1; instr_ready = NOT load_valid; load has priority over an instruction in the same cycle.
REQ-013 In ISSUE: load_ready=0, instr_ready=0.
REQ-014 Load handshake (load_valid AND load_ready) SHALL write load_data into R[load_addr] at that edge; FSM stays IDLE.
REQ-015 Instruction handshake SHALL latch sel0, sel1, selop, bypass, dst into registers at that edge and move FSM IDLE->ISSUE.
REQ-016 cell_sel0/cell_sel1/cell_selop/cell_bypass SHALL be the latched values; they hold steady through ISSUE.
REQ-017 At the edge ending ISSUE, SHALL write cell_result into R[dst], pulse done high for exactly the following cycle, move to IDLE.
REQ-018 Throughput: one instruction per 2 cycles max; accept at edge N, write visible and done high after edge N+1.
REQ-019 dst equal to a source register SHALL be legal; sources are sampled during ISSUE, destination written at its end.
REQ-020 Back-to-back: a new instruction may be accepted in the IDLE cycle while done is high and SHALL see the written value.
REQ-021 Inputs on an unhandshaken port SHALL be ignored; no register changes without a handshake or writeback.

Reset
REQ-022 When rst_n=0 at a clock edge: R0..R7=0, FSM=IDLE, latched controls=0, done=0.
REQ-023 Reset during ISSUE SHALL abort the instruction; no writeback, no done pulse.
REQ-024 Reset SHALL take priority over any handshake in the same cycle.

Configuration
REQ-025 Macro CELL_BANK_ZERO_FLAG_EN SHALL, when defined, add output zero_flag (1 bit): registered at each writeback to (cell_result == 0), held otherwise, reset to 0.
REQ-026 Without CELL_BANK_ZERO_FLAG_EN, port zero_flag and its logic SHALL be absent; all other behaviour unchanged.

Verification
REQ-027 Reset then loads R1=5, R2=3; instr sel0=1 sel1=2 selop=0 dst=3 -> done one cycle after ISSUE, reg3=8.
REQ-028 R1=5, R2=3, selop=1, dst=1 (dst=source) -> reg1=2; next instr reads 2.
REQ-029 load_valid and instr_valid both high in IDLE -> load taken, instr_ready=0; instr accepted next cycle.
REQ-030 Load attempted during ISSUE -> load_ready=0, target register unchanged.
REQ-031 rst_n low during ISSUE -> no done, all registers 0, FSM IDLE.
REQ-032 With CELL_BANK_ZERO_FLAG_EN: R4=7, sel0=4 sel1=4 selop=1 -> result 0, zero_flag=1; then bypass of R1=5 -> zero_flag=0.
